// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory-access / writeback stage.
package mem_wb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

    // Counter must hold 0 .. MAX_WAIT-1 with headroom.
    function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
        return $clog2(max_wait) + 1;
    endfunction

endpackage

// File: rtl/mem_wb_stage_wb_reg.sv
// Writeback output register: loads a result or a bubble every cycle.
module wb_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_wb_en,
    input  logic [REG_AW-1:0] i_dest,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_wb_en,
    output logic [REG_AW-1:0] o_dest,
    output logic [DATA_W-1:0] o_result
);

    logic              r_wb_en;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_result;

    // Load a new result when asked, otherwise insert a bubble (dest/result held).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en  <= RST_BIT;
            r_dest   <= '0;
            r_result <= '0;
        end else if (i_load) begin
            r_wb_en  <= i_wb_en;
            r_dest   <= i_dest;
            r_result <= i_data;
        end else begin
            r_wb_en  <= 1'b0;
        end
    end

    assign o_wb_en  = r_wb_en;
    assign o_dest   = r_dest;
    assign o_result = r_result;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: ALU results pass straight to the WB
// register, loads/stores go through a req/ack port and freeze upstream.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_wb_en,
    input  logic              ex_mem_r_en,
    input  logic              ex_mem_w_en,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_st_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              freeze,
    output logic [REG_AW-1:0] dest_wb,
    output logic [DATA_W-1:0] result_wb,
    output logic              writeback_en,
    output logic              mem_err
);

    localparam int CNT_W = wait_cnt_w(MAX_WAIT);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_AW-1:0] r_dest;
    logic              r_wb_en;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_latch;
    logic              w_abort;
    logic              w_count;
    logic              w_load;
    logic              w_ld_wb_en;
    logic [REG_AW-1:0] w_ld_dest;
    logic [DATA_W-1:0] w_ld_data;

    // Next-state and WB-register load selection.
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_abort    = 1'b0;
        w_count    = 1'b0;
        w_load     = 1'b0;
        w_ld_wb_en = 1'b0;
        w_ld_dest  = r_dest;
        w_ld_data  = mem_rdata;
        case (r_state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_r_en || ex_mem_w_en) begin
                        w_latch = 1'b1;
                        w_next  = ACCESS;
                    end else begin
                        w_load     = 1'b1;
                        w_ld_wb_en = ex_wb_en;
                        w_ld_dest  = ex_dest;
                        w_ld_data  = ex_alu_res;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    // Stores complete with a bubble; loads write back the read data.
                    w_load     = !r_we;
                    w_ld_wb_en = r_wb_en;
                    w_next     = IDLE;
                end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    w_count = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register, access latches, wait counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_STATE;
            r_we    <= RST_BIT;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dest  <= '0;
            r_wb_en <= RST_BIT;
            r_cnt   <= '0;
            r_err   <= RST_BIT;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                // Read wins when both enables are set.
                r_we    <= ex_mem_w_en & ~ex_mem_r_en;
                r_addr  <= {ex_alu_res[DATA_W-1:2], 2'b00};
                r_wdata <= ex_st_val;
                r_dest  <= ex_dest;
                r_wb_en <= ex_wb_en;
                r_cnt   <= '0;
            end else if (w_count) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    wb_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_wb_en  (w_ld_wb_en),
        .i_dest   (w_ld_dest),
        .i_data   (w_ld_data),
        .o_wb_en  (writeback_en),
        .o_dest   (dest_wb),
        .o_result (result_wb)
    );

    // Freeze covers the whole access, including the completing cycle.
    assign mem_req   = (r_state == ACCESS);
    assign freeze    = (r_state == ACCESS);
    assign mem_we    = (r_state == ACCESS) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_err   = r_err;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the pipelined core: accepts one EX-stage result per cycle, performs loads/stores through a request/acknowledge memory port with wait states, and drives the register-file write port (dest_wb, result_wb, writeback_en). It stalls upstream stages via freeze while a memory access is outstanding. The register file consumes these outputs and commits them on its negedge write.

## Interface
- DATA_W, 32, data and address width
- REG_AW, 4, register index width (16 architectural registers)
- MAX_WAIT, 15, ACCESS cycles without mem_ack before abort (1..255)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage presents an instruction this cycle
- ex_wb_en  in  1  instruction writes a register
- ex_mem_r_en  in  1  load
- ex_mem_w_en  in  1  store
- ex_dest  in  REG_AW  destination register
- ex_alu_res  in  DATA_W  ALU result / memory address
- ex_st_val  in  DATA_W  store data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  word address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  request completed this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- freeze  out  1  hold all upstream stage registers
- dest_wb  out  REG_AW  to register file
- result_wb  out  DATA_W  to register file
- writeback_en  out  1  to register file
- mem_err  out  1  sticky: an access timed out

## Operation
- FSM states IDLE, ACCESS.
- IDLE, ex_valid=0: WB register loads bubble (writeback_en=0); stay IDLE.
- IDLE, ex_valid=1, no memory op: WB register <= {ex_wb_en, ex_dest, ex_alu_res}; stay IDLE.
- IDLE, ex_valid=1, memory op: latch we (=ex_mem_w_en & !ex_mem_r_en), address {ex_alu_res[DATA_W-1:2],2'b00}, ex_st_val, ex_dest, ex_wb_en; WB register loads bubble; go ACCESS; wait counter <= 0.
- ex_mem_r_en and ex_mem_w_en both high: load (read wins, no write).
- ACCESS: mem_req=1, mem_we/addr/wdata from latches, stable until completion; ex_* ignored.
- ACCESS with mem_ack=1: load -> WB register <= {latched wb_en, latched dest, mem_rdata}; store -> bubble; go IDLE.
- ACCESS, no ack, counter = MAX_WAIT-1: abort, bubble, mem_err <= 1, go IDLE; otherwise counter increments.
- freeze = (state == ACCESS), combinational, including the ack/abort cycle, so the instruction held in EX is accepted in the following IDLE cycle exactly once.
- mem_err cleared only by reset.

## Timing
- Reset (async, rst=0): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, freeze=0, dest_wb=0, result_wb=0, writeback_en=0, mem_err=0. Reset mid-ACCESS drops mem_req immediately; a later mem_ack is ignored.
- Non-memory instruction: outputs valid 1 cycle after acceptance edge; one writeback per accepted instruction.
- Memory op: mem_req rises 1 cycle after acceptance; ack in N-th ACCESS cycle (N>=1) -> writeback_en high for exactly one cycle N+1 cycles after acceptance; freeze high for N cycles.
- mem_ack outside ACCESS is ignored.
- Back-to-back memory ops: one IDLE cycle between ACCESS periods.

## Structure
- Package mem_wb_pkg: state enum (IDLE, ACCESS), reset constants, wait-counter width ($clog2(MAX_WAIT)+1).
- Sub-module wb_reg: WB output register with load/bubble control and async active-low reset; FSM and memory latches stay in mem_wb_stage.

## Test plan
- ALU stream: ex_valid=1, ex_wb_en=1, dest 3, alu_res 0x20 then dest 4, 0x30 -> writeback_en 1 on consecutive cycles, (3,0x20) then (4,0x30), freeze never high.
- Load, ack in 3rd ACCESS cycle: addr 0x103, rdata 0xDEADBEEF -> mem_addr 0x100, freeze 3 cycles, then dest_wb/result_wb = (dest, 0xDEADBEEF), writeback_en one cycle.
- Store with 0-wait ack: addr 0x40, st_val 0x55 -> mem_we=1, mem_wdata=0x55 one cycle, writeback_en never 1; next EX instruction written back exactly once.
- Timeout: no ack -> mem_req dropped after MAX_WAIT=15 cycles, mem_err=1 stays, no writeback, next instruction proceeds.
- Async reset asserted mid-ACCESS -> all outputs 0 immediately; ack arriving after release has no effect.
- ex_mem_r_en=ex_mem_w_en=1 -> mem_we=0, load data written back.
